// File: rtl/kyber_arb_pkg.sv
// rtl/kyber_arb_pkg.sv - shared types, packet lengths and length lookup for the Kyber stream arbiter
// Purpose: arbiter FSM state encoding, public-key / ciphertext word counts per
//          Kyber rank, and helpers that validate k and map (source, k) to a length.
// Ports:   none (package).
package kyber_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_SER = 2'd1,
    GNT_CLI = 2'd2
  } arb_state_e;

  // Server packets carry the public key, client packets carry the ciphertext.
  localparam logic [8:0] PK_LEN_K2 = 9'd200;
  localparam logic [8:0] PK_LEN_K3 = 9'd296;
  localparam logic [8:0] PK_LEN_K4 = 9'd392;
  localparam logic [8:0] CT_LEN_K2 = 9'd192;
  localparam logic [8:0] CT_LEN_K3 = 9'd272;
  localparam logic [8:0] CT_LEN_K4 = 9'd392;

  function automatic logic k_valid(input logic [2:0] kv);
    return (kv == 3'd2) || (kv == 3'd3) || (kv == 3'd4);
  endfunction

  // cli = 1 selects the ciphertext length, 0 the public-key length.
  function automatic logic [8:0] pkt_len(input logic cli, input logic [2:0] kv);
    logic [8:0] len;
    case (kv)
      3'd2:    len = cli ? CT_LEN_K2 : PK_LEN_K2;
      3'd3:    len = cli ? CT_LEN_K3 : PK_LEN_K3;
      default: len = cli ? CT_LEN_K4 : PK_LEN_K4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/kyber_word_fifo.sv
// rtl/kyber_word_fifo.sv - first-word fall-through word FIFO for one arbiter source
// Purpose: buffers one source's words; dout always shows the head word.
// Ports:   clk, rst (async active-low), push/din (write), pop (read, ignored when
//          empty), dout (head word, meaningful only when !empty), full, empty.
module kyber_word_fifo
  import kyber_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_pop;
  logic          do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kyber_stream_arb.sv
// rtl/kyber_stream_arb.sv - packet-granular round-robin merge of Kyber server/client word streams
// Purpose: buffers server and client words in their own FIFOs and forwards whole
//          packets (length from k) onto one ready/valid stream, alternating sources.
// Ports:   clk, rst (async active-low), k (rank, sampled in IDLE),
//          valid_server/dout_server, valid_client/dout_client (no backpressure),
//          m_ready, m_valid, m_data, m_last, m_src (1 = client),
//          ovf_clr, ovf_server, ovf_client, cfg_err (sticky flags).
module kyber_stream_arb
  import kyber_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    k,
  input  logic          valid_server,
  input  logic [DW-1:0] dout_server,
  input  logic          valid_client,
  input  logic [DW-1:0] dout_client,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          m_src,
  input  logic          ovf_clr,
  output logic          ovf_server,
  output logic          ovf_client,
  output logic          cfg_err
);

  arb_state_e    state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [8:0]    len_q, len_d;
  logic          rr_cli_last_q, rr_cli_last_d;
  logic          cfg_set;
  logic          gnt_cli;

  logic          push_ser, push_cli;
  logic          pop_ser, pop_cli;
  logic          ser_full, ser_empty, cli_full, cli_empty;
  logic [DW-1:0] ser_head, cli_head;

  assign push_ser = valid_server && !cfg_err;
  assign push_cli = valid_client && !cfg_err;

  kyber_word_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_ser (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ser),
    .din   (dout_server),
    .pop   (pop_ser),
    .dout  (ser_head),
    .full  (ser_full),
    .empty (ser_empty)
  );

  kyber_word_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_cli (
    .clk   (clk),
    .rst   (rst),
    .push  (push_cli),
    .din   (dout_client),
    .pop   (pop_cli),
    .dout  (cli_head),
    .full  (cli_full),
    .empty (cli_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    rr_cli_last_d = rr_cli_last_q;
    cfg_set       = 1'b0;
    gnt_cli       = 1'b0;
    m_valid       = 1'b0;
    m_data        = '0;
    m_last        = 1'b0;
    m_src         = 1'b0;
    pop_ser       = 1'b0;
    pop_cli       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!k_valid(k)) begin
          cfg_set = 1'b1;
        end else if (!cfg_err) begin
          // Server goes first when both wait unless it had the previous packet.
          if (!ser_empty && (cli_empty || rr_cli_last_q)) begin
            state_d = GNT_SER;
            len_d   = pkt_len(1'b0, k);
          end else if (!cli_empty) begin
            state_d = GNT_CLI;
            len_d   = pkt_len(1'b1, k);
          end
        end
      end

      GNT_SER, GNT_CLI: begin
        gnt_cli = (state_q == GNT_CLI);
        m_src   = gnt_cli;
        m_valid = gnt_cli ? !cli_empty : !ser_empty;
        m_data  = m_valid ? (gnt_cli ? cli_head : ser_head) : '0;
        m_last  = m_valid && (cnt_q == len_q - 9'd1);
        if (m_valid && m_ready) begin
          pop_ser = !gnt_cli;
          pop_cli = gnt_cli;
          if (m_last) begin
            cnt_d         = '0;
            rr_cli_last_d = gnt_cli;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      rr_cli_last_q <= 1'b1;
      ovf_server    <= 1'b0;
      ovf_client    <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      rr_cli_last_q <= rr_cli_last_d;
      // A new error in the same cycle as ovf_clr keeps the flag set.
      ovf_server    <= (push_ser && ser_full && !pop_ser) || (ovf_server && !ovf_clr);
      ovf_client    <= (push_cli && cli_full && !pop_cli) || (ovf_client && !ovf_clr);
      cfg_err       <= cfg_set || (cfg_err && !ovf_clr);
    end
  end

endmodule

// File: tb/tb_kyber_stream_arb.sv
// tb/tb_kyber_stream_arb.sv - scoreboard bench for kyber_stream_arb
module tb_kyber_stream_arb;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    k;
  logic          valid_server;
  logic [DW-1:0] dout_server;
  logic          valid_client;
  logic [DW-1:0] dout_client;
  logic          m_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_src;
  logic          ovf_clr;
  logic          ovf_server;
  logic          ovf_client;
  logic          cfg_err;

  always #5 clk = ~clk;

  kyber_stream_arb #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .k            (k),
    .valid_server (valid_server),
    .dout_server  (dout_server),
    .valid_client (valid_client),
    .dout_client  (dout_client),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_src        (m_src),
    .ovf_clr      (ovf_clr),
    .ovf_server   (ovf_server),
    .ovf_client   (ovf_client),
    .cfg_err      (cfg_err)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_xfer = 0;
  int          pkt_cnt = 0;
  logic        cur_src = 1'b0;
  logic        bubble_next = 1'b0;
  logic [1:0]  ovf_m = 2'b00;
  logic        cfg_exp = 1'b0;
  logic [31:0] exp_ser[$];
  logic [31:0] exp_cli[$];
  logic        pkt_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_len(input logic cli, input logic [2:0] kv);
    case (kv)
      3'd2:    return cli ? 192 : 200;
      3'd3:    return cli ? 272 : 296;
      default: return 392;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, check the outputs, update the model.
  task automatic tick(input logic vs, input logic [31:0] ds, input logic vc,
                      input logic [31:0] dc, input logic rdy, input logic clr);
    logic       s;
    logic       last_e;
    logic [1:0] set;
    valid_server = vs;
    dout_server  = ds;
    valid_client = vc;
    dout_client  = dc;
    m_ready      = rdy;
    ovf_clr      = clr;
    set          = 2'b00;
    #1;
    check("ovf_server", 32'(ovf_server), 32'(ovf_m[0]));
    check("ovf_client", 32'(ovf_client), 32'(ovf_m[1]));
    check("cfg_err", 32'(cfg_err), 32'(cfg_exp));
    if (bubble_next) begin
      check("bubble", 32'(m_valid), 32'd0);
      bubble_next = 1'b0;
    end
    if (pkt_cnt != 0)
      check("mid_valid", 32'(m_valid),
            32'(((cur_src ? exp_cli.size() : exp_ser.size()) != 0)));
    if (!m_valid) begin
      check("last_novalid", 32'(m_last), 32'd0);
    end else begin
      s = m_src;
      if (pkt_cnt == 0) cur_src = s;
      else check("src_hold", 32'(m_src), 32'(cur_src));
      if ((s ? exp_cli.size() : exp_ser.size()) == 0) begin
        check("spurious_valid", 32'(m_valid), 32'd0);
      end else begin
        last_e = (pkt_cnt == exp_len(s, k) - 1);
        check("data", m_data, s ? exp_cli[0] : exp_ser[0]);
        check("last", 32'(m_last), 32'(last_e));
        if (rdy) begin
          if (s) void'(exp_cli.pop_front());
          else   void'(exp_ser.pop_front());
          n_xfer++;
          if (last_e) begin
            pkt_cnt     = 0;
            bubble_next = 1'b1;
            pkt_log.push_back(s);
          end else begin
            pkt_cnt++;
          end
        end
      end
    end
    if (vs && !cfg_exp) begin
      if (exp_ser.size() < DEPTH) exp_ser.push_back(ds);
      else set[0] = 1'b1;
    end
    if (vc && !cfg_exp) begin
      if (exp_cli.size() < DEPTH) exp_cli.push_back(dc);
      else set[1] = 1'b1;
    end
    ovf_m = (ovf_m & {2{!clr}}) | set;
    @(negedge clk);
  endtask

  task automatic model_clear();
    exp_ser.delete();
    exp_cli.delete();
    pkt_log.delete();
    pkt_cnt     = 0;
    bubble_next = 1'b0;
    ovf_m       = 2'b00;
    cfg_exp     = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    valid_server = 1'b0;
    valid_client = 1'b0;
    m_ready      = 1'b0;
    ovf_clr      = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_ser.size() == 0 && exp_cli.size() == 0) break;
      tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(exp_ser.size() + exp_cli.size()), 32'd0);
    repeat (2) tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int si;
    int ci;

    rst          = 1'b0;
    k            = 3'd4;
    valid_server = 1'b0;
    dout_server  = '0;
    valid_client = 1'b0;
    dout_client  = '0;
    m_ready      = 1'b0;
    ovf_clr      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_src", 32'(m_src), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_ovf_server", 32'(ovf_server), 32'd0);
    check("rst_ovf_client", 32'(ovf_client), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b1;

    // k=4 server packet at full rate.
    k = 3'd4;
    base = n_xfer;
    for (int i = 0; i < 392; i++) tick(1'b1, 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
    drain(100);
    check("k4_xfers", 32'(n_xfer - base), 32'd392);
    check("k4_pkts", 32'(pkt_log.size()), 32'd1);
    if (pkt_log.size() == 1) check("k4_src", 32'(pkt_log[0]), 32'd0);

    // k=2 simultaneous server/client bursts: server packet first, then client.
    do_reset();
    k = 3'd2;
    base = n_xfer;
    si = 0;
    ci = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic vs;
      logic vc;
      if (si >= 200 && ci >= 192 && exp_ser.size() == 0 && exp_cli.size() == 0) break;
      vs = (si < 200);
      vc = (ci < 192) && (exp_cli.size() < DEPTH);
      tick(vs, 32'(si), vc, 32'hC000_0000 | 32'(ci), 1'b1, 1'b0);
      if (vs) si++;
      if (vc) ci++;
    end
    drain(10);
    check("k2_xfers", 32'(n_xfer - base), 32'd392);
    check("k2_pkts", 32'(pkt_log.size()), 32'd2);
    if (pkt_log.size() == 2) begin
      check("k2_first_src", 32'(pkt_log[0]), 32'd0);
      check("k2_second_src", 32'(pkt_log[1]), 32'd1);
    end

    // k=3 client overflow with downstream stalled, then clear and drain.
    do_reset();
    k = 3'd3;
    for (int i = 0; i < 20; i++) tick(1'b0, 32'd0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    check("ovf_client_set", 32'(ovf_client), 32'd1);
    tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("ovf_client_clr", 32'(ovf_client), 32'd0);
    base = n_xfer;
    for (int i = 0; i < 20; i++) tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("ovf_drain_xfers", 32'(n_xfer - base), 32'd16);
    check("ovf_drain_valid", 32'(m_valid), 32'd0);

    // k=3 server packet with m_ready toggling every cycle.
    do_reset();
    k = 3'd3;
    base = n_xfer;
    si = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic vs;
      if (si >= 296 && exp_ser.size() == 0) break;
      vs = (si < 296) && (exp_ser.size() < DEPTH);
      tick(vs, 32'h3000_0000 + 32'(si), 1'b0, 32'd0, cyc[0], 1'b0);
      if (vs) si++;
    end
    drain(10);
    check("k3_stall_xfers", 32'(n_xfer - base), 32'd296);
    check("k3_stall_pkts", 32'(pkt_log.size()), 32'd1);

    // Illegal rank blocks everything until cleared.
    do_reset();
    k = 3'd5;
    tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cfg_exp = 1'b1;
    for (int i = 0; i < 4; i++)
      tick(1'b1, 32'hDEAD_0000 + 32'(i), 1'b1, 32'hBEEF_0000 + 32'(i), 1'b1, 1'b0);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    check("cfg_m_valid", 32'(m_valid), 32'd0);
    k = 3'd2;
    tick(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    cfg_exp = 1'b0;
    check("cfg_err_clr", 32'(cfg_err), 32'd0);
    base = n_xfer;
    for (int i = 0; i < 192; i++) tick(1'b0, 32'd0, 1'b1, 32'h5000_0000 + 32'(i), 1'b1, 1'b0);
    drain(100);
    check("cfg_recover_xfers", 32'(n_xfer - base), 32'd192);
    check("cfg_recover_pkts", 32'(pkt_log.size()), 32'd1);
    if (pkt_log.size() == 1) check("cfg_recover_src", 32'(pkt_log[0]), 32'd1);

    // Reset mid-packet, then a full fresh packet.
    do_reset();
    k = 3'd4;
    base = n_xfer;
    for (int i = 0; i < 392; i++) begin
      if (n_xfer - base >= 100) break;
      tick(1'b1, 32'h7000_0000 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
    end
    check("pre_rst_xfers", 32'(n_xfer - base), 32'd100);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    valid_server = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_last", 32'(m_last), 32'd0);
    check("midrst_m_src", 32'(m_src), 32'd0);
    check("midrst_m_data", m_data, 32'd0);
    check("midrst_ovf_server", 32'(ovf_server), 32'd0);
    check("midrst_ovf_client", 32'(ovf_client), 32'd0);
    check("midrst_cfg_err", 32'(cfg_err), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    base = n_xfer;
    for (int i = 0; i < 392; i++) tick(1'b1, 32'h9000_0000 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
    drain(100);
    check("post_rst_xfers", 32'(n_xfer - base), 32'd392);
    check("post_rst_pkts", 32'(pkt_log.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
